// File: rtl/arb_client_port.sv
// arb_client_port: four per-client FIFOs feeding a shared output register.
// The request vector mirrors FIFO occupancy for a 4-way arbiter. The
// arbiter's one-hot grant pops the winning head entry into the output
// register, which is drained with a valid/ready handshake. Malformed grants
// (multi-hot, or pointing at an empty FIFO) raise a sticky error flag and
// are otherwise ignored.
module arb_client_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic [3:0]          request,
  input  logic [3:0]          grant,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_src,
  input  logic                out_ready,
  output logic                err_grant
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage (never reset) and per-client pointer/occupancy state
  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [AW-1:0]     rd_ptr_q [4];
  logic [AW-1:0]     rd_ptr_d [4];
  logic [AW-1:0]     wr_ptr_q [4];
  logic [AW-1:0]     wr_ptr_d [4];
  logic [CW-1:0]     count_q  [4];
  logic [CW-1:0]     count_d  [4];

  // Output register and sticky error flag
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [1:0]        out_src_q,   out_src_d;
  logic              err_q,       err_d;

  logic [3:0] push;
  logic [3:0] pop;
  logic [1:0] pop_idx;
  logic       pop_any;
  logic       can_load;
  logic       grant_multi;
  logic       grant_empty;
  logic       grant_err;

  // Ready/request come straight from registered counts, so they never glitch
  always_comb begin
    in_ready = '0;
    request  = '0;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = !reset && (count_q[i] != CW'(DEPTH));
      request[i]  = (count_q[i] != '0);
    end
  end

  // Decode pushes, validate the grant and select at most one FIFO to pop
  always_comb begin
    can_load    = !out_valid_q || out_ready;
    grant_multi = (grant & (grant - 4'd1)) != 4'd0;
    grant_empty = (grant & ~request) != 4'd0;
    grant_err   = grant_multi || grant_empty;
    push        = in_valid & in_ready;
    pop         = '0;
    pop_idx     = '0;
    for (int i = 0; i < 4; i++) begin
      if ((grant == (4'd1 << i)) && request[i] && can_load && !grant_err) begin
        pop[i]  = 1'b1;
        pop_idx = 2'(i);
      end
    end
    pop_any = |pop;
  end

  // Next-state for pointers, counts, output register and error flag
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (pop_any) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[pop_idx][rd_ptr_q[pop_idx]];
      out_src_d   = pop_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    err_d = err_q || grant_err;
  end

  // Control and output state; reset discards everything queued or held
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  // FIFO payload writes; storage contents are don't-care until pushed
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign err_grant = err_q;

endmodule

// File: doc/arb_client_port.md
# arb_client_port

Client-side counterpart to the 4-way weighted round-robin arbiter. It buffers commands from four clients in per-client FIFOs and drives the arbiter's `request` vector from FIFO occupancy. It consumes the arbiter's one-hot `grant` to pop the winning client's head entry onto a single shared output stream with a valid/ready handshake. It also flags protocol violations on `grant`.

## Interface
Parameters:
- `DATA_W`, 8, payload width per client entry.
- `DEPTH`, 4, entries per client FIFO; power of 2, ≥2.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  4  — per-client push strobe.
- `in_data`  in  4*DATA_W  — client i payload at bits [i*DATA_W +: DATA_W].
- `in_ready`  out  4  — client i FIFO can accept.
- `request`  out  4  — to arbiter; bit i = client i FIFO non-empty.
- `grant`  in  4  — from arbiter; one-hot or zero expected.
- `out_valid`  out  1  — output register holds an entry.
- `out_data`  out  DATA_W  — output payload.
- `out_src`  out  2  — index of client that supplied `out_data`.
- `out_ready`  in  1  — downstream accepts when high with `out_valid`.
- `err_grant`  out  1  — sticky protocol-error flag.

## Operation
- Per-client FIFO i holds `rd_ptr`, `wr_ptr` (log2(DEPTH) bits, wrap mod DEPTH) and `count` (log2(DEPTH)+1 bits, range 0..DEPTH).
- Push i: `in_valid[i] && in_ready[i]`; write at `wr_ptr`, increment `wr_ptr`.
- `in_ready[i] = !reset && count[i] != DEPTH`. It does not look ahead at same-cycle pops; a full FIFO refuses a push even if popped that cycle.
- `request[i] = (count[i] != 0)`. Combinational from registered count, so glitch-free.
- `can_load = !out_valid || out_ready`.
- Pop i requires all of:
  - `grant == (1<<i)`,
  - `request[i]`,
  - `can_load`.
- On pop:
  - head → `out_data`, i → `out_src`,
  - `out_valid` ← 1,
  - increment `rd_ptr[i]`.
- No pop and `out_ready` high → `out_valid` ← 0. `out_data`/`out_src` hold their last values.
- Grant while `!can_load`: ignored; no pop, no error. The arbiter re-grants later.
- Simultaneous push and pop on the same FIFO: `count` unchanged, both pointers advance.
- Error conditions: `grant` has more than one bit set, or `grant[i]` with `count[i]==0`.
  - Either sets `err_grant` ← 1 (sticky until reset).
  - No pop occurs that cycle.
- `grant == 0`: no action.
- No state machine beyond FIFO and output-register state. Output register states are EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY → FULL on pop.
  - FULL → EMPTY on `out_ready` without pop.
  - FULL → FULL on pop with `out_ready`, or on stall.

## Timing
- Reset (synchronous, checked at rising edge): all counts and pointers 0, `out_valid`=0, `out_data`=0, `out_src`=0, `err_grant`=0.
  - Consequently `request`=0, and `in_ready`=0 while reset is high, then 4'b1111.
- Reset mid-operation: all queued entries and any held output are discarded; no partial state survives.
- Push accepted at edge N → `request[i]`=1 from edge N onward (1-cycle latency).
- Grant sampled at edge M with pop conditions true → `out_valid`/`out_data`/`out_src` valid after edge M (1-cycle latency).
- `request[i]` falls after edge M if that pop emptied FIFO i.
- Sustained throughput: one entry per cycle when `out_ready`=1 and grants are back-to-back.
- FIFO memory is not reset. Only pointers and counts are reset.

## Test plan
- Reset then idle: `in_ready`=4'b1111, `request`=0, `out_valid`=0, `err_grant`=0 for 10 cycles.
- Push 0xA1 to client 0 and 0xB3 to client 3. Then drive `grant`=4'b0001, then 4'b1000, with `out_ready`=1. Required: `out_data`/`out_src` = 0xA1/0, then 0xB3/3, on consecutive cycles; `request`=0 afterwards.
- Push 4 entries (0x10..0x13) to client 1. Required: `in_ready[1]`=0, a 5th push is dropped, grants drain 0x10..0x13 in order, and `in_ready[1]` returns to 1 after the first pop. Pointer wrap is checked by pushing 2 more and draining them.
- `out_ready`=0 with `out_valid`=1 while `grant`=4'b0010 repeats. Required: no pop, `count[1]` unchanged, `out_data` stable. On `out_ready`=1 the next grant pops.
- Drive `grant`=4'b0101, and separately `grant`=4'b0100 with client 2 empty. Required: `err_grant`=1 after the edge, held until reset, with no FIFO state change.
- Assert reset with 3 entries queued and `out_valid`=1. Required: next cycle `request`=0, `out_valid`=0, and subsequent grants produce nothing.
